// File: rtl/rtc_bus_scheduler.sv
// Round-robin scheduler that shares the RTC register bus between field-edit writers and a periodic
// read-back scan. Defining RTC_SCHED_TIMEOUT_EN adds a per-phase timeout that aborts a stalled access.
module rtc_bus_scheduler #(
  parameter int          N_REQ          = 3,
  parameter logic [7:0]  RD_BASE        = 8'h21,
  parameter int          NUM_RD         = 3,
  parameter int          REFRESH_CYCLES = 1000,
  parameter int          TIMEOUT        = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic               cmd_valid,
  output logic               cmd_ad,
  output logic               cmd_wr,
  output logic [7:0]         cmd_bus,
  input  logic               cmd_done,
  input  logic [7:0]         cmd_rdata,
  output logic               rd_valid,
  output logic [3:0]         rd_index,
  output logic [7:0]         rd_data,
  output logic               err
);

  localparam int SLOTS = N_REQ + 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int TW    = $clog2(REFRESH_CYCLES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t           state, next_state;
  logic [SW-1:0]    rr_ptr, cur_slot, grant_slot, slot_hi, slot_lo;
  logic             found_hi, found_lo, any_cand;
  logic [SLOTS-1:0] cand;
  logic [7:0]       cur_addr, cur_data, win_addr, win_data, scan_addr;
  logic             cur_wr, win_wr;
  logic [TW-1:0]    timer;
  logic             scan_pend, wrap, scan_last, phase_expired, timeout;
  logic [3:0]       scan_idx;
  logic             valid_d, ad_d, wr_d, busy_d, rdv_d;
  logic [7:0]       bus_d;
  logic [N_REQ-1:0] ack_d;

  // The scan occupies the highest slot so it takes part in the same rotation as the writers.
  assign cand      = {scan_pend, req};
  assign scan_addr = RD_BASE + {4'd0, scan_idx};
  assign wrap      = enable && (timer == TW'(REFRESH_CYCLES - 1));
  assign scan_last = (state == DONE) && !cur_wr && (scan_idx == 4'(NUM_RD - 1));

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT + 1);
  logic [PW-1:0] phase_cnt;

  always_ff @(posedge clk) begin
    if (reset || (next_state != state))
      phase_cnt <= '0;
    else
      phase_cnt <= phase_cnt + PW'(1);
  end

  assign phase_expired = (phase_cnt == PW'(TIMEOUT - 1));
`else
  assign phase_expired = 1'b0;
`endif

  // Lowest candidate above rr_ptr wins; otherwise wrap around to the lowest candidate at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    slot_hi  = '0;
    slot_lo  = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        if (k > int'(rr_ptr)) begin
          found_hi = 1'b1;
          slot_hi  = SW'(k);
        end else begin
          found_lo = 1'b1;
          slot_lo  = SW'(k);
        end
      end
    end
    any_cand   = found_hi || found_lo;
    grant_slot = found_hi ? slot_hi : slot_lo;
  end

  always_comb begin
    win_addr = scan_addr;
    win_data = 8'h00;
    win_wr   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_slot == SW'(k)) begin
        win_addr = req_addr[8*k +: 8];
        win_data = req_data[8*k +: 8];
        win_wr   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      IDLE: if (enable && any_cand) next_state = ADDR;
      ADDR: begin
        if (cmd_done) begin
          next_state = DATA;
        end else if (phase_expired) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      DATA: begin
        if (cmd_done) begin
          next_state = DONE;
        end else if (phase_expired) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so they line up with the state register.
  always_comb begin
    valid_d = 1'b0;
    ad_d    = 1'b0;
    wr_d    = 1'b0;
    bus_d   = 8'h00;
    rdv_d   = 1'b0;
    ack_d   = '0;
    busy_d  = (next_state != IDLE);
    case (next_state)
      ADDR: begin
        valid_d = 1'b1;
        wr_d    = 1'b1;
        bus_d   = (state == IDLE) ? win_addr : cur_addr;
      end
      DATA: begin
        valid_d = 1'b1;
        ad_d    = 1'b1;
        wr_d    = cur_wr;
        bus_d   = cur_data;
      end
      DONE: begin
        rdv_d = !cur_wr;
        for (int k = 0; k < N_REQ; k++)
          ack_d[k] = cur_wr && (cur_slot == SW'(k));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_ad    <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_bus   <= 8'h00;
      busy      <= 1'b0;
      ack       <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= valid_d;
      cmd_ad    <= ad_d;
      cmd_wr    <= wr_d;
      cmd_bus   <= bus_d;
      busy      <= busy_d;
      ack       <= ack_d;
      rd_valid  <= rdv_d;
      err       <= timeout;
    end
  end

  // A timer wrap that coincides with the final scan read wins, so a fresh scan is queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      cur_slot  <= '0;
      cur_addr  <= 8'h00;
      cur_data  <= 8'h00;
      cur_wr    <= 1'b0;
      rd_data   <= 8'h00;
      rd_index  <= 4'd0;
      timer     <= '0;
      scan_pend <= 1'b0;
      scan_idx  <= 4'd0;
    end else begin
      if ((state == IDLE) && (next_state == ADDR)) begin
        rr_ptr   <= grant_slot;
        cur_slot <= grant_slot;
        cur_addr <= win_addr;
        cur_data <= win_data;
        cur_wr   <= win_wr;
      end
      if ((state == DATA) && cmd_done && !cur_wr) begin
        rd_data  <= cmd_rdata;
        rd_index <= scan_idx;
      end
      if (enable)
        timer <= wrap ? '0 : timer + TW'(1);
      if ((state == DONE) && !cur_wr)
        scan_idx <= scan_last ? 4'd0 : scan_idx + 4'd1;
      if (wrap)
        scan_pend <= 1'b1;
      else if (scan_last)
        scan_pend <= 1'b0;
    end
  end

endmodule
